// File: rtl/uart1rx_pkg.sv
// Shared UART package: receiver/transmitter FSM state encoding.
// Imported by uart1rx (and by uart1tx elsewhere in the codebase).
package uart1rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart1rx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   reset - asynchronous active-high reset, both flops load RESET_VALUE
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart1rx.sv
// uart1rx: 8N1 UART receiver, LSB first, oversampled by CLOCK_DIV clk/bit.
// Ports:
//   clk             - sole clock, rising edge
//   reset           - asynchronous active-high reset
//   rx              - asynchronous serial line, idles high
//   data            - last correctly framed byte
//   interrupt       - level flag, new byte available
//   interrupt_clear - synchronous level clear of interrupt
// A byte with a bad stop bit is discarded and the FSM parks in BREAK until
// the line returns high. A good byte always overwrites data (overrun is
// silent) and a set of interrupt wins over a simultaneous clear.
module uart1rx
  import uart1rx_pkg::*;
#(
  parameter int CLOCK_DIV          = 16,
  parameter int CLOCK_COUNTER_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       interrupt,
  input  logic       interrupt_clear
);

  localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_HALF = CLOCK_COUNTER_BITS'(CLOCK_DIV/2 - 1);
  localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_FULL = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);

  logic                          rxs;
  uart_state_t                   state;
  logic [CLOCK_COUNTER_BITS-1:0] counter;
  logic [2:0]                    bit_idx;
  logic [UART_DATA_BITS-1:0]     shift;

  sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      interrupt <= 1'b0;
    end else begin
      // Clear first; a good stop bit later in this block overrides it.
      if (interrupt_clear) interrupt <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            counter <= '0;
          end
        end

        START: begin
          if (counter == CNT_HALF) begin
            if (!rxs) begin
              state   <= DATA;
              counter <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;  // too short to be a start bit
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        DATA: begin
          if (counter == CNT_FULL) begin
            shift[bit_idx] <= rxs;
            counter        <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        STOP: begin
          if (counter == CNT_FULL) begin
            counter <= '0;
            if (rxs) begin
              data      <= shift;
              interrupt <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= BREAK;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        BREAK: begin
          if (rxs) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart1rx.sv
// Testbench for uart1rx (CLOCK_DIV=16). A frame-level model schedules the
// expected data/interrupt update for each good frame at a fixed edge
// offset from the first edge that sees the start bit; reset cancels any
// pending frame. Outputs are compared against the model every cycle, plus
// literal checks at key points.
module tb_uart1rx;

  localparam int CD  = 16;
  // Rising edges from the first edge seeing rx low up to and including
  // the edge that raises interrupt: 2 sync + 1 detect + half bit + 9 bits.
  localparam int LAT = 9*CD + CD/2 + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       interrupt_clear = 1'b0;
  logic [7:0] data;
  logic       interrupt;

  always #5 clk = ~clk;

  uart1rx #(.CLOCK_DIV(CD), .CLOCK_COUNTER_BITS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .data            (data),
    .interrupt       (interrupt),
    .interrupt_clear (interrupt_clear)
  );

  int checks = 0;
  int failures = 0;
  int ecnt = 0;  // index of the next rising clk edge

  typedef struct {
    int         e;
    logic [7:0] b;
  } ev_t;

  ev_t        sched_q[$];
  ev_t        push_ev;
  logic [7:0] exp_data = 8'h00;
  logic       exp_int = 1'b0;
  bit         cmp_en = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Model: a scheduled byte lands on its edge (set beats clear).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_data <= 8'h00;
      exp_int  <= 1'b0;
      sched_q.delete();
    end else if (sched_q.size() > 0 && sched_q[0].e == ecnt) begin
      exp_data <= sched_q[0].b;
      exp_int  <= 1'b1;
      void'(sched_q.pop_front());
    end else if (interrupt_clear) begin
      exp_int <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (data !== exp_data || interrupt !== exp_int) begin
        failures++;
        if (failures <= 20)
          $display("FAIL model_cmp edge=%0d data=%02h int=%0b required data=%02h int=%0b",
                   ecnt, data, interrupt, exp_data, exp_int);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  // Called at a negedge; the next rising edge is the first to see rx low.
  task automatic send(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      push_ev.e = ecnt + LAT - 1;
      push_ev.b = b;
      sched_q.push_back(push_ev);
    end
    rx = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CD) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CD) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    interrupt_clear = 1'b1;
    @(negedge clk);
    interrupt_clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", ecnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b77;
    b77 = 8'h77;

    repeat (3) @(negedge clk);
    chk("reset_data", data, 8'h00);
    chk("reset_int", {7'b0, interrupt}, 8'h00);
    reset = 1'b0;
    cmp_en = 1'b1;
    idle(10);

    // Short low pulse: rejected at mid start bit.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("glitch_int", {7'b0, interrupt}, 8'h00);
    chk("glitch_data", data, 8'h00);

    // 0x55 with exact latency.
    fork
      send(8'h55, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        chk("lat_before_int", {7'b0, interrupt}, 8'h00);
        chk("lat_before_data", data, 8'h00);
        @(negedge clk);
        chk("lat_int", {7'b0, interrupt}, 8'h01);
        chk("lat_data", data, 8'h55);
      end
    join
    idle(5);
    pulse_clear();
    chk("clear_int", {7'b0, interrupt}, 8'h00);

    // Framing error, break, then good frame.
    send(8'hA3, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("ferr_int", {7'b0, interrupt}, 8'h00);
    chk("ferr_data", data, 8'h55);
    idle(20);
    send(8'h3C, 1'b1);
    idle(5);
    chk("after_break_data", data, 8'h3C);
    chk("after_break_int", {7'b0, interrupt}, 8'h01);

    // Clear between frames, then clear during completion edge.
    pulse_clear();
    send(8'h12, 1'b1);
    idle(5);
    chk("b12_data", data, 8'h12);
    chk("b12_int", {7'b0, interrupt}, 8'h01);
    pulse_clear();
    chk("b12_cleared_int", {7'b0, interrupt}, 8'h00);
    idle(5);
    fork
      send(8'h34, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        interrupt_clear = 1'b1;
        @(negedge clk);
        interrupt_clear = 1'b0;
        chk("set_wins_int", {7'b0, interrupt}, 8'h01);
        chk("set_wins_data", data, 8'h34);
      end
    join
    idle(5);

    // Back-to-back overrun.
    send(8'h01, 1'b1);
    chk("ovr_first_data", data, 8'h01);
    send(8'hFF, 1'b1);
    idle(5);
    chk("ovr_data", data, 8'hFF);
    chk("ovr_int", {7'b0, interrupt}, 8'h01);

    // Reset in the middle of bit 4 of 0x77.
    push_ev.e = ecnt + LAT - 1;
    push_ev.b = b77;
    sched_q.push_back(push_ev);
    rx = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b77[i];
      repeat (CD) @(negedge clk);
    end
    rx = b77[4];
    repeat (CD/2) @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_data", data, 8'h00);
    chk("midrst_int", {7'b0, interrupt}, 8'h00);
    reset = 1'b0;
    idle(30);
    chk("post_rst_data", data, 8'h00);
    chk("post_rst_int", {7'b0, interrupt}, 8'h00);
    send(8'h81, 1'b1);
    idle(5);
    chk("b81_data", data, 8'h81);
    chk("b81_int", {7'b0, interrupt}, 8'h01);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart1rx.md
UART1RX -- requirements
Module: uart1rx

Interface
REQ-001 SHALL have parameter CLOCK_DIV, default 16: clk cycles per UART bit; must be an even number of at least 4.
REQ-002 SHALL have parameter CLOCK_COUNTER_BITS, default 4: bit-counter width; must satisfy 2^CLOCK_COUNTER_BITS >= CLOCK_DIV.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idles high; format is 8N1, LSB first.
REQ-006 data  output  8  last correctly framed received byte.
REQ-007 interrupt  output  1  level flag: a new byte is available.
REQ-008 interrupt_clear  input  1  synchronous level clear of interrupt.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value (rxs).
REQ-010 SHALL implement the states IDLE, START, DATA, STOP and BREAK, with a cycle counter and a 3-bit bit index.
REQ-011 IDLE: when rxs=0, SHALL go to START with counter=0.
REQ-012 START: when counter=CLOCK_DIV/2-1 (mid start bit), the next state SHALL be decided by rxs.
  - rxs=0: go to DATA with counter=0 and bit index=0.
  - rxs=1: treat as a glitch and return to IDLE.
REQ-013 DATA: each time counter=CLOCK_DIV-1, SHALL sample rxs into shift register bit [index] (LSB first) and reset the counter.
  - After index 7, go to STOP.
REQ-014 STOP: when counter=CLOCK_DIV-1, SHALL act on the sampled stop bit.
  - rxs=1: load data with the shift register, set interrupt, go to IDLE.
  - rxs=0 (framing error): discard the byte, leave data and interrupt unchanged, go to BREAK.
REQ-015 BREAK: SHALL wait until rxs=1, then go to IDLE.
REQ-016 Both data and interrupt SHALL change only on a good stop bit; data stays stable otherwise.
REQ-017 Latency: interrupt SHALL rise exactly 9*CLOCK_DIV + CLOCK_DIV/2 + 3 cycles after the first clk edge that sees rx low (this count includes the synchronizer).
REQ-018 interrupt_clear=1 SHALL clear interrupt on the next edge.
  - If a good stop bit completes in the same cycle, the set wins and interrupt stays 1.
REQ-019 Overrun: a new good byte while interrupt=1 SHALL overwrite data; interrupt stays 1 and no error flag is raised.
REQ-020 Back-to-back frames SHALL be received: IDLE re-detects a start bit in the cycle after STOP completes.
REQ-021 interrupt_clear SHALL have no effect on the receive FSM.

Reset
REQ-022 While reset=1, the following SHALL hold:
  - state=IDLE; counter=0; bit index=0.
  - shift register=0x00, data=0x00, interrupt=0.
  - synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame without updating data.
  - After release, reception resumes only on a new falling edge of rx.

Structure
REQ-024 State encoding localparams (IDLE, START, DATA, STOP, BREAK) SHALL live in a shared uart package, also used by uart1tx.
REQ-025 The synchronizer SHALL be a separate sub-module, sync2 (parameter reset value 1); everything else stays flat in uart1rx.

Verification (CLOCK_DIV=16)
REQ-026 Send 0x55 at 16 clk/bit -> data=0x55 and interrupt=1 exactly 155 cycles after the start edge; data unchanged before that.
REQ-027 rx low for 4 cycles, then high -> FSM returns to IDLE; interrupt stays 0 and data stays 0x00.
REQ-028 Send 0xA3 with stop bit=0, then rx held low 40 cycles, then a good 0x3C frame -> 0xA3 is dropped with interrupt 0; then data=0x3C and interrupt=1.
REQ-029 Receive 0x12, pulse interrupt_clear one cycle, then receive 0x34 -> interrupt falls, rises again, and data=0x34.
  - Also drive interrupt_clear=1 in the exact completion cycle -> interrupt stays 1.
REQ-030 Receive 0x01 then 0xFF back-to-back without clear -> data=0xFF and interrupt stays 1 (overrun).
REQ-031 Assert reset during bit 4 of 0x77, release, then send 0x81 -> data=0x81 with no spurious byte from the aborted frame.
